mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline: consumes EX/MEM register outputs and drives a wait-stated data memory through a req/ack handshake.
- Stalls the pipeline while an access is outstanding, aborts accesses that time out or are misaligned, and registers results into the MEM/WB boundary.
- Sits between the EX/MEM pipeline register and the writeback mux.

Parameters:
- TIMEOUT, 16, max cycles a request stays outstanding without dmem_ack before abort (min 2)
- ADDR_W, 32, data address width

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- Mem_Read_M  in  1  load in MEM
- Mem_Write_M  in  1  store in MEM
- Mem_To_Reg_M  in  1  writeback select
- Reg_Write_M  in  1  register write enable
- ALU_Result_M  in  32  effective address / ALU result
- Write_Data_M  in  32  store data
- Write_Reg_M  in  5  destination register
- dmem_req  out  1  memory request
- dmem_we  out  1  1=write, 0=read
- dmem_addr  out  ADDR_W  word-aligned address
- dmem_wdata  out  32  store data
- dmem_rdata  in  32  load data, valid when dmem_ack=1
- dmem_ack  in  1  access complete, single-cycle pulse
- stall_M  out  1  freeze IF/ID/EX and EX/MEM
- bus_err  out  1  one-cycle pulse on timeout abort
- align_err  out  1  one-cycle pulse on misaligned access
- stall_cycles  out  32  saturating count of stall_M cycles
- Read_Data_W, ALU_Result_W  out  32  MEM/WB data
- Write_Reg_W  out  5  MEM/WB destination
- Reg_Write_W, Mem_To_Reg_W  out  1  MEM/WB controls

Behaviour:
- Reset (async, rst_n=0): state IDLE, timeout counter 0, stall_cycles 0, all registered outputs 0. dmem_req drops immediately. A reset mid-WAIT abandons the access; any late ack is ignored.
- access = Mem_Read_M | Mem_Write_M. Mem_Write_M has priority if both are set (dmem_we=1, no load data).
- misaligned = access & (ALU_Result_M[1:0] != 0).
- Misaligned access:
  - Never raises dmem_req or stall_M.
  - align_err pulses registered (the cycle after the instruction leaves MEM).
  - W gets a bubble: Reg_Write_W=0, Mem_To_Reg_W=0.
- dmem_req = access & ~misaligned & (state==IDLE | state==WAIT). It is combinational, so a request can issue in the same cycle the instruction enters MEM.
- dmem_addr = {ALU_Result_M[ADDR_W-1:2],2'b00}; dmem_wdata = Write_Data_M; dmem_we = Mem_Write_M.
- FSM, states IDLE and WAIT:
  - IDLE, dmem_req & dmem_ack: zero-wait completion, stay IDLE, stall_M=0.
  - IDLE, dmem_req & ~dmem_ack: go WAIT, counter<=1, stall_M=1.
  - WAIT, dmem_ack: complete, go IDLE, counter<=0, stall_M=0.
  - WAIT, ~dmem_ack & counter==TIMEOUT-1: abort, go IDLE, bus_err pulse next cycle, stall_M=0 this cycle, W gets a bubble.
  - WAIT otherwise: counter++, stall_M=1.
- stall_M is combinational: dmem_req & ~dmem_ack & ~abort. Upstream holds all *_M inputs stable while stall_M=1.
- MEM/WB register, on each posedge:
  - stall_M=1: insert a bubble (Reg_Write_W=0, Mem_To_Reg_W=0); data fields are don't-care and are held.
  - stall_M=0: latch ALU_Result_M, Write_Reg_M and Mem_To_Reg_M.
  - Reg_Write_W <= Reg_Write_M & ~misaligned & ~abort.
  - Read_Data_W <= dmem_rdata on a completed load, else 0.
- Non-memory instructions pass through to W with 1-cycle latency and no stall.
- An ack received while no request is outstanding is ignored.
- stall_cycles increments every cycle stall_M=1 and saturates at 32'hFFFFFFFF.

Test Plan:
- Reset mid-WAIT: rst_n low during WAIT -> dmem_req and stall_M go 0 asynchronously; all W outputs 0; state IDLE after release.
- Zero-wait load: addr 0x100, ack in the same cycle, rdata 0xDEADBEEF -> stall_M never 1; next cycle Read_Data_W=0xDEADBEEF, Mem_To_Reg_W=1, Reg_Write_W=1.
- 3-wait store: addr 0x204, data 0x12345678, ack on the 4th cycle -> stall_M=1 for 3 cycles; dmem_we=1 held; 3 bubbles into W; stall_cycles=3.
- Timeout: load with no ack, TIMEOUT=16 -> stall_M=1 for cycles 0..14, abort on cycle 15; bus_err pulses once; Reg_Write_W=0; state IDLE.
- Misaligned load: addr 0x102 -> no dmem_req; align_err pulses once; Reg_Write_W=0; no stall.
- ALU instruction: ALU_Result_M=0x55, Write_Reg_M=7, Reg_Write_M=1 -> next cycle ALU_Result_W=0x55, Write_Reg_W=7, Reg_Write_W=1; back-to-back with a following zero-wait load, no stall.

Source files
------------

// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage and a wait-stated data memory.
// The stage drives the request side; the memory answers with a one-cycle ack and read data.
interface mem_access_stage_if #(
    parameter int ADDR_W = 32
);
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [31:0]       dmem_wdata;
    logic [31:0]       dmem_rdata;
    logic              dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: issues data-memory accesses over a req/ack bus, stalls while one is outstanding,
// aborts on timeout or misalignment, and registers the result into the MEM/WB boundary.
module mem_access_stage #(
    parameter int TIMEOUT = 16,
    parameter int ADDR_W  = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                Mem_Read_M,
    input  logic                Mem_Write_M,
    input  logic                Mem_To_Reg_M,
    input  logic                Reg_Write_M,
    input  logic [31:0]         ALU_Result_M,
    input  logic [31:0]         Write_Data_M,
    input  logic [4:0]          Write_Reg_M,
    mem_access_stage_if.master  dmem,
    output logic                stall_M,
    output logic                bus_err,
    output logic                align_err,
    output logic [31:0]         stall_cycles,
    output logic [31:0]         Read_Data_W,
    output logic [31:0]         ALU_Result_W,
    output logic [4:0]          Write_Reg_W,
    output logic                Reg_Write_W,
    output logic                Mem_To_Reg_W
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             access, misaligned, req, done, abort;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign access     = Mem_Read_M | Mem_Write_M;
    assign misaligned = access & (ALU_Result_M[1:0] != 2'b00);
    // Gating with rst_n makes the request vanish the moment reset is asserted.
    assign req        = rst_n & access & ~misaligned;
    assign done       = req & dmem.dmem_ack;

    assign dmem.dmem_req   = req;
    assign dmem.dmem_we    = Mem_Write_M;
    assign dmem.dmem_addr  = {ALU_Result_M[ADDR_W-1:2], 2'b00};
    assign dmem.dmem_wdata = Write_Data_M;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (req && !dmem.dmem_ack) begin
                    state_nxt = WAIT;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            WAIT: begin
                if (!req || dmem.dmem_ack) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign stall_M = req & ~dmem.dmem_ack & ~abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            stall_cycles <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (stall_M) stall_cycles <= sat_inc(stall_cycles);
        end
    end

    // MEM/WB boundary: stalls and aborted/misaligned accesses become bubbles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Read_Data_W  <= '0;
            ALU_Result_W <= '0;
            Write_Reg_W  <= '0;
            Reg_Write_W  <= 1'b0;
            Mem_To_Reg_W <= 1'b0;
            bus_err      <= 1'b0;
            align_err    <= 1'b0;
        end else begin
            if (!stall_M) begin
                ALU_Result_W <= ALU_Result_M;
                Write_Reg_W  <= Write_Reg_M;
            end
            Reg_Write_W  <= Reg_Write_M & ~stall_M & ~misaligned & ~abort;
            Mem_To_Reg_W <= Mem_To_Reg_M & ~stall_M & ~misaligned & ~abort;
            Read_Data_W  <= (done && !Mem_Write_M) ? dmem.dmem_rdata : 32'd0;
            bus_err      <= abort;
            align_err    <= misaligned;
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed instruction sequences, a cycle-level reference model,
// and literal expectations at the key points of each scenario.
module tb_mem_access_stage;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        Mem_Read_M, Mem_Write_M, Mem_To_Reg_M, Reg_Write_M;
    logic [31:0] ALU_Result_M, Write_Data_M;
    logic [4:0]  Write_Reg_M;
    logic        stall_M, bus_err, align_err;
    logic [31:0] stall_cycles, Read_Data_W, ALU_Result_W;
    logic [4:0]  Write_Reg_W;
    logic        Reg_Write_W, Mem_To_Reg_W;

    int checks = 0;
    int errors = 0;

    mem_access_stage_if #(.ADDR_W(32)) bus ();

    mem_access_stage #(.TIMEOUT(TIMEOUT), .ADDR_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .Mem_Read_M   (Mem_Read_M),
        .Mem_Write_M  (Mem_Write_M),
        .Mem_To_Reg_M (Mem_To_Reg_M),
        .Reg_Write_M  (Reg_Write_M),
        .ALU_Result_M (ALU_Result_M),
        .Write_Data_M (Write_Data_M),
        .Write_Reg_M  (Write_Reg_M),
        .dmem         (bus),
        .stall_M      (stall_M),
        .bus_err      (bus_err),
        .align_err    (align_err),
        .stall_cycles (stall_cycles),
        .Read_Data_W  (Read_Data_W),
        .ALU_Result_W (ALU_Result_W),
        .Write_Reg_W  (Write_Reg_W),
        .Reg_Write_W  (Reg_Write_W),
        .Mem_To_Reg_W (Mem_To_Reg_W)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: what W and the flags must show, derived from the instruction in MEM.
    int          waited;
    logic [31:0] m_stalls, x_rd, x_alu;
    logic [4:0]  x_wreg;
    logic        x_rw, x_mtr, x_bus, x_align;
    logic        acc, mis, e_req, e_abort, e_stall;

    always @(negedge clk) begin
        if (!rst_n) begin
            waited = 0; m_stalls = 0; x_rd = 0; x_alu = 0; x_wreg = 0;
            x_rw = 0; x_mtr = 0; x_bus = 0; x_align = 0;
        end
        acc     = Mem_Read_M || Mem_Write_M;
        mis     = acc && (ALU_Result_M % 4 != 0);
        e_req   = rst_n && acc && !mis;
        e_abort = e_req && !bus.dmem_ack && (waited == TIMEOUT - 1);
        e_stall = e_req && !bus.dmem_ack && !e_abort;

        check("m_req", bus.dmem_req, e_req);
        check("m_stall", stall_M, e_stall);
        if (e_req) begin
            check("m_addr", bus.dmem_addr, ALU_Result_M & ~32'h3);
            check("m_we", bus.dmem_we, Mem_Write_M);
            check("m_wdata", bus.dmem_wdata, Write_Data_M);
        end
        check("m_rdata_w", Read_Data_W, x_rd);
        check("m_alu_w", ALU_Result_W, x_alu);
        check("m_wreg_w", Write_Reg_W, x_wreg);
        check("m_rw_w", Reg_Write_W, x_rw);
        check("m_mtr_w", Mem_To_Reg_W, x_mtr);
        check("m_bus_err", bus_err, x_bus);
        check("m_align_err", align_err, x_align);
        check("m_stall_cycles", stall_cycles, m_stalls);

        if (rst_n) begin
            x_rd    = (e_req && bus.dmem_ack && !Mem_Write_M) ? bus.dmem_rdata : 32'd0;
            if (!e_stall) begin
                x_alu  = ALU_Result_M;
                x_wreg = Write_Reg_M;
            end
            x_rw    = Reg_Write_M && !e_stall && !mis && !e_abort;
            x_mtr   = Mem_To_Reg_M && !e_stall && !mis && !e_abort;
            x_bus   = e_abort;
            x_align = mis;
            if (e_stall && m_stalls != 32'hFFFF_FFFF) m_stalls = m_stalls + 1;
            waited  = e_stall ? waited + 1 : 0;
        end
    end

    task automatic drive(input logic rd, input logic wr, input logic mtr, input logic rw,
                         input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wreg,
                         input logic ack, input logic [31:0] rdata);
        @(posedge clk);
        #1;
        Mem_Read_M = rd; Mem_Write_M = wr; Mem_To_Reg_M = mtr; Reg_Write_M = rw;
        ALU_Result_M = alu; Write_Data_M = wd; Write_Reg_M = wreg;
        bus.dmem_ack = ack; bus.dmem_rdata = rdata;
    endtask

    task automatic nop();
        drive(0, 0, 0, 0, 32'd0, 32'd0, 5'd0, 0, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        Mem_Read_M = 0; Mem_Write_M = 0; Mem_To_Reg_M = 0; Reg_Write_M = 0;
        ALU_Result_M = 0; Write_Data_M = 0; Write_Reg_M = 0;
        bus.dmem_ack = 0; bus.dmem_rdata = 0;
        repeat (2) @(negedge clk);
        check("reset_rw_w", Reg_Write_W, 0);
        check("reset_stall_cycles", stall_cycles, 0);
        check("reset_req", bus.dmem_req, 0);
        nop();
        rst_n = 1'b1;
        @(negedge clk);

        // ALU op followed back-to-back by a zero-wait load
        drive(0, 0, 0, 1, 32'h55, 32'd0, 5'd7, 0, 32'd0);
        @(negedge clk);
        drive(1, 0, 1, 1, 32'h100, 32'd0, 5'd3, 1, 32'hDEADBEEF);
        @(negedge clk);
        check("alu_alu_w", ALU_Result_W, 32'h55);
        check("alu_wreg_w", Write_Reg_W, 7);
        check("alu_rw_w", Reg_Write_W, 1);
        check("zw_stall", stall_M, 0);
        check("zw_req", bus.dmem_req, 1);
        nop();
        @(negedge clk);
        check("zw_rdata_w", Read_Data_W, 32'hDEADBEEF);
        check("zw_mtr_w", Mem_To_Reg_W, 1);
        check("zw_rw_w", Reg_Write_W, 1);

        // Store with three wait states
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 0, 0, 32'h204, 32'h12345678, 5'd0, (i == 3), 32'd0);
            @(negedge clk);
            check("st_stall", stall_M, (i < 3));
            check("st_we", bus.dmem_we, 1);
            check("st_addr", bus.dmem_addr, 32'h204);
        end
        nop();
        @(negedge clk);
        check("st_stall_cycles", stall_cycles, 3);

        // Load that never gets an ack
        for (int i = 0; i < 16; i++) begin
            drive(1, 0, 1, 1, 32'h300, 32'd0, 5'd5, 0, 32'd0);
            @(negedge clk);
            check("to_stall", stall_M, (i < 15));
            check("to_req", bus.dmem_req, 1);
        end
        nop();
        @(negedge clk);
        check("to_bus_err", bus_err, 1);
        check("to_rw_w", Reg_Write_W, 0);
        check("to_stall_cycles", stall_cycles, 18);
        nop();
        @(negedge clk);
        check("to_bus_err_clear", bus_err, 0);

        // Misaligned load
        drive(1, 0, 1, 1, 32'h102, 32'd0, 5'd6, 0, 32'd0);
        @(negedge clk);
        check("mis_req", bus.dmem_req, 0);
        check("mis_stall", stall_M, 0);
        nop();
        @(negedge clk);
        check("mis_align_err", align_err, 1);
        check("mis_rw_w", Reg_Write_W, 0);
        nop();
        @(negedge clk);
        check("mis_align_clear", align_err, 0);

        // Read and write together: the write wins, no load data
        drive(1, 1, 0, 0, 32'h108, 32'h0BADF00D, 5'd0, 1, 32'hAAAA5555);
        @(negedge clk);
        check("both_we", bus.dmem_we, 1);
        nop();
        @(negedge clk);
        check("both_rdata_w", Read_Data_W, 0);

        // Reset while waiting; a late ack must be ignored
        drive(1, 0, 1, 1, 32'h400, 32'd0, 5'd9, 0, 32'd0);
        @(negedge clk);
        drive(1, 0, 1, 1, 32'h400, 32'd0, 5'd9, 0, 32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_async_req", bus.dmem_req, 0);
        check("rst_async_stall", stall_M, 0);
        bus.dmem_ack = 1'b1;
        @(negedge clk);
        check("rst_rw_w", Reg_Write_W, 0);
        check("rst_alu_w", ALU_Result_W, 0);
        drive(0, 0, 0, 0, 32'd0, 32'd0, 5'd0, 1, 32'h11111111);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_late_ack_stall", stall_M, 0);
        drive(1, 0, 1, 1, 32'h104, 32'd0, 5'd4, 1, 32'hCAFEF00D);
        @(negedge clk);
        check("post_rst_stall", stall_M, 0);
        nop();
        @(negedge clk);
        check("post_rst_rdata_w", Read_Data_W, 32'hCAFEF00D);
        check("post_rst_stall_cycles", stall_cycles, 0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
